// File: rtl/layered_mux_pkg.sv
// Shared helpers for the layered offsets mux: index-width sizing used by the
// top level and by the priority encoder.
package layered_mux_pkg;

  localparam int MIN_CH = 2;
  localparam int MAX_CH = 16;

  // Width of a channel index; a single channel still gets a 1-bit index.
  function automatic int ch_idx_w(input int n);
    return ($clog2(n) > 0) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/layered_offsets_mux_prio_enc.sv
// Combinational priority encoder: lowest set bit of eff wins, idx is 0 when
// nothing is set.
module prio_enc_n
  import layered_mux_pkg::*;
#(
  parameter int N = 4,
  localparam int IDX_W = ch_idx_w(N)
) (
  input  logic [N-1:0]     eff,
  output logic             valid,
  output logic [IDX_W-1:0] idx
);

  // Scan from the top so the lowest index is the last assignment to stick.
  always_comb begin
    valid = |eff;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (eff[i]) idx = IDX_W'(i);
    end
  end

endmodule

// File: rtl/layered_offsets_mux.sv
// N-layer draw mux: picks the highest-priority enabled requester per pixel,
// forwards its offsets through a PIPE-deep register chain, and keeps
// per-frame overlap statistics for collision logic.
module layered_offsets_mux
  import layered_mux_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int OFF_W  = 11,
  parameter int PIPE   = 1,
  parameter int CNT_W  = 16,
  localparam int CH_IDX_W = ch_idx_w(NUM_CH)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    startOfFrame,
  input  logic [NUM_CH-1:0]       layerEnable,
  input  logic [NUM_CH-1:0]       drawRequest,
  input  logic [NUM_CH*OFF_W-1:0] offsetX,
  input  logic [NUM_CH*OFF_W-1:0] offsetY,
  output logic                    drawRequestOut,
  output logic [OFF_W-1:0]        offset_x,
  output logic [OFF_W-1:0]        offset_y,
  output logic [CH_IDX_W-1:0]     winnerIdx,
  output logic                    overlap,
  output logic [CNT_W-1:0]        frameOverlapCnt,
  output logic [NUM_CH-1:0]       frameHitMask
);

  typedef logic [OFF_W-1:0] offset_t;

  localparam int STG_W = 2 + 2 * OFF_W + CH_IDX_W;

  logic [NUM_CH-1:0]   eff;
  logic [NUM_CH-1:0]   hit;
  logic                win_valid;
  logic [CH_IDX_W-1:0] win_idx;
  logic                overlap_now;
  offset_t             sel_x;
  offset_t             sel_y;

  logic [STG_W-1:0]            stg_in;
  logic [PIPE-1:0][STG_W-1:0]  stg;

  logic [CNT_W-1:0]  run_cnt;
  logic [NUM_CH-1:0] run_mask;

  // Masking is purely combinational so an enable change applies to this pixel.
  assign eff = drawRequest & layerEnable;

  // Clearing the lowest set bit leaves something only if two or more were set.
  assign overlap_now = |(eff & (eff - NUM_CH'(1)));
  assign hit         = overlap_now ? eff : '0;

  prio_enc_n #(
    .N(NUM_CH)
  ) u_prio (
    .eff  (eff),
    .valid(win_valid),
    .idx  (win_idx)
  );

  always_comb begin
    sel_x = '0;
    sel_y = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (win_valid && (win_idx == CH_IDX_W'(i))) begin
        sel_x = offsetX[i*OFF_W +: OFF_W];
        sel_y = offsetY[i*OFF_W +: OFF_W];
      end
    end
  end

  assign stg_in = {win_valid, sel_x, sel_y, win_idx, overlap_now};

  // All five per-pixel outputs travel together so their latency always matches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stg <= '0;
    end else begin
      stg[0] <= stg_in;
      for (int i = 1; i < PIPE; i++) begin
        stg[i] <= stg[i-1];
      end
    end
  end

  assign {drawRequestOut, offset_x, offset_y, winnerIdx, overlap} = stg[PIPE-1];

  // Stats see the unpipelined pixel; the frame-start pixel opens the new frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      run_cnt         <= '0;
      run_mask        <= '0;
      frameOverlapCnt <= '0;
      frameHitMask    <= '0;
    end else if (startOfFrame) begin
      frameOverlapCnt <= run_cnt;
      frameHitMask    <= run_mask;
      run_cnt         <= overlap_now ? CNT_W'(1) : '0;
      run_mask        <= hit;
    end else begin
      if (overlap_now && !(&run_cnt)) run_cnt <= run_cnt + CNT_W'(1);
      run_mask <= run_mask | hit;
    end
  end

endmodule

// File: tb/tb_layered_offsets_mux.sv
// Directed bench for layered_offsets_mux: a default instance (PIPE=1,
// CNT_W=16) and a PIPE=2, CNT_W=4 instance share the same stimulus.
module tb_layered_offsets_mux;

  logic        clk;
  logic        reset;
  logic        startOfFrame;
  logic [3:0]  layerEnable;
  logic [3:0]  drawRequest;
  logic [43:0] offsetX;
  logic [43:0] offsetY;

  logic        dro1, dro2;
  logic [10:0] ox1, oy1, ox2, oy2;
  logic [1:0]  idx1, idx2;
  logic        ovl1, ovl2;
  logic [15:0] fcnt1;
  logic [3:0]  fcnt2;
  logic [3:0]  fmask1, fmask2;

  int checks = 0;
  int errors = 0;

  layered_offsets_mux u1 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .layerEnable(layerEnable), .drawRequest(drawRequest),
    .offsetX(offsetX), .offsetY(offsetY),
    .drawRequestOut(dro1), .offset_x(ox1), .offset_y(oy1),
    .winnerIdx(idx1), .overlap(ovl1),
    .frameOverlapCnt(fcnt1), .frameHitMask(fmask1)
  );

  layered_offsets_mux #(.PIPE(2), .CNT_W(4)) u2 (
    .clk(clk), .reset(reset), .startOfFrame(startOfFrame),
    .layerEnable(layerEnable), .drawRequest(drawRequest),
    .offsetX(offsetX), .offsetY(offsetY),
    .drawRequestOut(dro2), .offset_x(ox2), .offset_y(oy2),
    .winnerIdx(idx2), .overlap(ovl2),
    .frameOverlapCnt(fcnt2), .frameHitMask(fmask2)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One pixel: drive at edge+1, advance past the next edge, settle 1 time unit.
  task automatic apply(input logic [3:0] dr, input logic [3:0] en, input logic sof);
    drawRequest  = dr;
    layerEnable  = en;
    startOfFrame = sof;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset        = 1'b1;
    startOfFrame = 1'b0;
    layerEnable  = 4'b0000;
    drawRequest  = 4'b0000;
    #1;
    checks++;
    if ({dro1, ox1, oy1, idx1, ovl1, fcnt1, fmask1} !== 46'd0) begin
      errors++;
      $display("FAIL reset_u1: got %h expected 0", {dro1, ox1, oy1, idx1, ovl1, fcnt1, fmask1});
    end
    checks++;
    if ({dro2, ox2, oy2, idx2, ovl2, fcnt2, fmask2} !== 34'd0) begin
      errors++;
      $display("FAIL reset_u2: got %h expected 0", {dro2, ox2, oy2, idx2, ovl2, fcnt2, fmask2});
    end
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(4'b0000, 4'b0000, 1'b0);
    apply(4'b0000, 4'b0000, 1'b0);
  endtask

  // {req, x, y, idx, ovl}
  task automatic test_priority;
    logic [3:0]  v_dr [6];
    logic [3:0]  v_en [6];
    logic [25:0] v_exp [6];
    v_dr[0] = 4'b0110; v_en[0] = 4'b1111; v_exp[0] = {1'b1, 11'd10, 11'd201, 2'd1, 1'b1};
    v_dr[1] = 4'b0001; v_en[1] = 4'b1110; v_exp[1] = {1'b0, 11'd0,  11'd0,   2'd0, 1'b0};
    v_dr[2] = 4'b1000; v_en[2] = 4'b1111; v_exp[2] = {1'b1, 11'd30, 11'd203, 2'd3, 1'b0};
    v_dr[3] = 4'b1111; v_en[3] = 4'b1111; v_exp[3] = {1'b1, 11'd5,  11'd200, 2'd0, 1'b1};
    v_dr[4] = 4'b1100; v_en[4] = 4'b0111; v_exp[4] = {1'b1, 11'd20, 11'd202, 2'd2, 1'b0};
    v_dr[5] = 4'b0000; v_en[5] = 4'b1111; v_exp[5] = 26'd0;
    for (int i = 0; i < 6; i++) begin
      apply(v_dr[i], v_en[i], 1'b0);
      checks++;
      if ({dro1, ox1, oy1, idx1, ovl1} !== v_exp[i]) begin
        errors++;
        $display("FAIL prio_u1[%0d]: got %h expected %h", i, {dro1, ox1, oy1, idx1, ovl1}, v_exp[i]);
      end
      if (i > 0) begin
        checks++;
        if ({dro2, ox2, oy2, idx2, ovl2} !== v_exp[i-1]) begin
          errors++;
          $display("FAIL prio_u2[%0d]: got %h expected %h", i - 1, {dro2, ox2, oy2, idx2, ovl2}, v_exp[i-1]);
        end
      end
    end
  endtask

  task automatic test_frame_stats;
    // Frame since reset held overlaps at vectors 0 (0110) and 3 (1111).
    apply(4'b0000, 4'b1111, 1'b1);
    checks++;
    if ({fcnt1, fmask1, fcnt2, fmask2} !== {16'd2, 4'b1111, 4'd2, 4'b1111}) begin
      errors++;
      $display("FAIL stats_since_reset: got %h expected %h", {fcnt1, fmask1, fcnt2, fmask2}, {16'd2, 4'b1111, 4'd2, 4'b1111});
    end
    for (int i = 0; i < 5; i++) begin
      apply(4'b1001, 4'b1111, 1'b0);
      apply(4'b0001, 4'b1111, 1'b0);
    end
    checks++;
    if ({fcnt1, fmask1} !== {16'd2, 4'b1111}) begin
      errors++;
      $display("FAIL stats_hold: got %h expected %h", {fcnt1, fmask1}, {16'd2, 4'b1111});
    end
    apply(4'b0000, 4'b1111, 1'b1);
    checks++;
    if ({fcnt1, fmask1, fcnt2, fmask2} !== {16'd5, 4'b1001, 4'd5, 4'b1001}) begin
      errors++;
      $display("FAIL stats_five: got %h expected %h", {fcnt1, fmask1, fcnt2, fmask2}, {16'd5, 4'b1001, 4'd5, 4'b1001});
    end
    for (int i = 0; i < 3; i++) apply(4'b0001, 4'b1111, 1'b0);
    apply(4'b0000, 4'b1111, 1'b1);
    checks++;
    if ({fcnt1, fmask1, fcnt2, fmask2} !== {16'd0, 4'b0000, 4'd0, 4'b0000}) begin
      errors++;
      $display("FAIL stats_empty: got %h expected 0", {fcnt1, fmask1, fcnt2, fmask2});
    end
  endtask

  task automatic test_sof_overlap;
    apply(4'b0011, 4'b1111, 1'b0);
    apply(4'b0011, 4'b1111, 1'b0);
    apply(4'b0011, 4'b1111, 1'b1);
    checks++;
    if ({fcnt1, fmask1} !== {16'd2, 4'b0011}) begin
      errors++;
      $display("FAIL sof_latch: got %h expected %h", {fcnt1, fmask1}, {16'd2, 4'b0011});
    end
    apply(4'b0000, 4'b1111, 1'b0);
    apply(4'b0000, 4'b1111, 1'b0);
    apply(4'b0000, 4'b1111, 1'b1);
    checks++;
    if ({fcnt1, fmask1, fcnt2, fmask2} !== {16'd1, 4'b0011, 4'd1, 4'b0011}) begin
      errors++;
      $display("FAIL sof_carry: got %h expected %h", {fcnt1, fmask1, fcnt2, fmask2}, {16'd1, 4'b0011, 4'd1, 4'b0011});
    end
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 20; i++) apply(4'b1111, 4'b1111, 1'b0);
    apply(4'b0000, 4'b1111, 1'b1);
    checks++;
    if ({fcnt1, fmask1} !== {16'd20, 4'b1111}) begin
      errors++;
      $display("FAIL sat_u1: got %h expected %h", {fcnt1, fmask1}, {16'd20, 4'b1111});
    end
    checks++;
    if ({fcnt2, fmask2} !== {4'd15, 4'b1111}) begin
      errors++;
      $display("FAIL sat_u2: got %h expected %h", {fcnt2, fmask2}, {4'd15, 4'b1111});
    end
  endtask

  task automatic test_reset_mid;
    for (int i = 0; i < 3; i++) apply(4'b0101, 4'b1111, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({dro1, ox1, oy1, idx1, ovl1, fcnt1, fmask1} !== 46'd0) begin
      errors++;
      $display("FAIL reset_mid_u1: got %h expected 0", {dro1, ox1, oy1, idx1, ovl1, fcnt1, fmask1});
    end
    checks++;
    if ({dro2, ox2, oy2, idx2, ovl2, fcnt2, fmask2} !== 34'd0) begin
      errors++;
      $display("FAIL reset_mid_u2: got %h expected 0", {dro2, ox2, oy2, idx2, ovl2, fcnt2, fmask2});
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    apply(4'b0110, 4'b1111, 1'b0);
    checks++;
    if ({fcnt1, fmask1} !== 20'd0) begin
      errors++;
      $display("FAIL reset_mid_stats: got %h expected 0", {fcnt1, fmask1});
    end
    apply(4'b0110, 4'b1111, 1'b0);
    apply(4'b0000, 4'b1111, 1'b1);
    checks++;
    if ({fcnt1, fmask1, fcnt2, fmask2} !== {16'd2, 4'b0110, 4'd2, 4'b0110}) begin
      errors++;
      $display("FAIL reset_mid_frame: got %h expected %h", {fcnt1, fmask1, fcnt2, fmask2}, {16'd2, 4'b0110, 4'd2, 4'b0110});
    end
  endtask

  initial begin
    offsetX = {11'd30, 11'd20, 11'd10, 11'd5};
    offsetY = {11'd203, 11'd202, 11'd201, 11'd200};
    test_reset();
    test_priority();
    test_frame_stats();
    test_sof_overlap();
    test_saturation();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
